lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit in the MEM stage, directly downstream of the EX-stage ALU.
- Takes the ALU result as the effective address plus store data and funct3, and runs one data-memory access over a req/ack handshake.
- Drives per-byte write masks and returns sign- or zero-extended load data to writeback.
- Holds `o_busy` high for the whole access so the pipeline controller stalls the earlier stages.

Parameters:
- TIMEOUT, 255: cycles to wait in REQ for `i_mem_ack` before aborting with error; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; TIMEOUT must be less than 2^CNT_W.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  memory op present from EX
- i_lsu_wren  in  1  1 = store, 0 = load
- i_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_alu_data  in  32  effective address from ALU
- i_st_data  in  32  rs2 store data
- o_busy  out  1  unit not in IDLE; stall upstream
- o_done  out  1  one-cycle completion pulse
- o_ld_data  out  32  extended load result, valid when `o_done`
- o_err  out  1  misaligned, illegal funct3, or timeout; qualified by `o_done`
- o_mem_req  out  1  memory request
- o_mem_we  out  1  write enable
- o_mem_addr  out  32  word address: {addr[31:2], 2'b00}
- o_mem_wdata  out  32  lane-replicated store data
- o_mem_bmask  out  4  byte enables; loads drive 4'b1111
- i_mem_ack  in  1  memory accepted / read data valid
- i_mem_rdata  in  32  read word

Behaviour:
- Reset (async, `i_rst_n`=0): state IDLE; every output 0, including `o_ld_data`; counter 0. Asserting reset mid-access drops `o_mem_req` immediately; no `o_done` follows.
- FSM: IDLE, REQ, DONE.
- IDLE:
  - `i_valid` sampled high at an edge accepts the op. Address, data, funct3 and wren are registered; upstream need not hold them afterwards.
  - Legal, aligned op -> REQ.
  - Error op -> DONE with `o_err`=1, and no `o_mem_req` is ever raised.
- Error conditions: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 outside {000,001,010,100,101}; store with funct3 100 or 101.
- REQ:
  - `o_mem_req`=1; `o_mem_we`, `o_mem_addr`, `o_mem_wdata`, `o_mem_bmask` stable for the whole state.
  - `i_mem_ack` high at an edge: capture `i_mem_rdata` -> DONE. The earliest ack is the first edge after entering REQ.
  - Counter increments each REQ cycle. If it reaches TIMEOUT (TIMEOUT != 0) without ack: -> DONE with `o_err`=1, and `o_mem_req` drops.
- DONE: `o_done`=1 for exactly one cycle -> IDLE. `o_ld_data` and `o_err` hold until the next accept.
- `o_busy` = (state != IDLE). `i_valid` is ignored in REQ and DONE.
- Minimum latency: accept edge -> REQ -> ack edge -> DONE cycle. Back-to-back ops run at 1 per 3 cycles minimum.
- Store lanes:
  - SB: wdata = {4{d[7:0]}}, bmask = 4'b0001 << addr[1:0].
  - SH: wdata = {2{d[15:0]}}, bmask = addr[1] ? 1100 : 0011.
  - SW: wdata = d, bmask = 1111.
- Load extraction:
  - Byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes rdata.
  - Stores return `o_ld_data` = 0.
- Ack arriving in IDLE or DONE is ignored.

Test Plan:
- LB, addr 0x1003, rdata 0x80FF_1234, ack one cycle after req -> `o_mem_addr`=0x1000, bmask 1111, `o_ld_data`=0xFFFF_FF80, `o_err`=0. `o_done` pulses on the 3rd cycle after the accept edge.
- LHU, addr 0x2002, rdata 0xBEEF_0000 -> `o_ld_data`=0x0000_BEEF; LH on the same data -> 0xFFFF_BEEF.
- SH, addr 0x3002, data 0x1234_ABCD -> wdata 0xABCD_ABCD, bmask 1100, we=1; SB at addr 0x3001 -> bmask 0010, wdata 0xCDCD_CDCD.
- LW at addr 0x4001 -> no `o_mem_req` ever; `o_done`=1 with `o_err`=1 one cycle after accept; same for funct3 011.
- TIMEOUT=4, `i_mem_ack` held 0 -> `o_mem_req` high 4 cycles then drops; `o_done`+`o_err` pulse; `o_busy` falls after DONE.
- Assert `i_rst_n`=0 in REQ -> `o_mem_req`/`o_busy` go 0 with no clock edge and no `o_done`. `i_valid` pulsed while busy -> that op is never executed.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: one data-memory access per accepted op over a req/ack
// handshake, with byte-lane store steering, load extension and an optional ack timeout.
module lsu_mem_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_data,
    input  logic [31:0] i_st_data,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_ld_data,
    output logic        o_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam logic             TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic              err_q, err_d;
    logic [31:0]       addr_q, st_data_q;
    logic [2:0]        funct3_q;
    logic              wren_q;

    logic              accept;
    logic              op_err;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_ext;

    assign accept = (state_q == S_IDLE) && i_valid;

    // Illegal or misaligned ops never reach the memory bus.
    always_comb begin
        op_err = 1'b0;
        case (i_funct3)
            3'b000:  op_err = 1'b0;
            3'b001:  op_err = i_alu_data[0];
            3'b010:  op_err = |i_alu_data[1:0];
            3'b100:  op_err = i_lsu_wren;
            3'b101:  op_err = i_lsu_wren | i_alu_data[0];
            default: op_err = 1'b1;
        endcase
    end

    always_comb begin
        ld_byte = 8'h00;
        case (addr_q[1:0])
            2'd0: ld_byte = i_mem_rdata[7:0];
            2'd1: ld_byte = i_mem_rdata[15:8];
            2'd2: ld_byte = i_mem_rdata[23:16];
            2'd3: ld_byte = i_mem_rdata[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = i_mem_rdata;
        endcase
    end

    // State register and result registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ld_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_data_q <= ld_data_d;
            err_q     <= err_d;
        end
    end

    // Operands are captured at accept so upstream can move on immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q    <= '0;
            st_data_q <= '0;
            funct3_q  <= '0;
            wren_q    <= 1'b0;
        end else if (accept) begin
            addr_q    <= i_alu_data;
            st_data_q <= i_st_data;
            funct3_q  <= i_funct3;
            wren_q    <= i_lsu_wren;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_data_d = ld_data_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    ld_data_d = '0;
                    err_d     = op_err;
                    cnt_d     = '0;
                    state_d   = op_err ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (i_mem_ack) begin
                    ld_data_d = wren_q ? 32'h0 : ld_ext;
                    state_d   = S_DONE;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; bus fields are forced to zero outside REQ.
    always_comb begin
        o_busy      = (state_q != S_IDLE);
        o_done      = (state_q == S_DONE);
        o_ld_data   = ld_data_q;
        o_err       = err_q;
        o_mem_req   = (state_q == S_REQ);
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_bmask = '0;
        if (state_q == S_REQ) begin
            o_mem_we   = wren_q;
            o_mem_addr = {addr_q[31:2], 2'b00};
            if (!wren_q) begin
                o_mem_bmask = 4'b1111;
            end else begin
                case (funct3_q[1:0])
                    2'b00: begin
                        o_mem_wdata = {4{st_data_q[7:0]}};
                        o_mem_bmask = 4'b0001 << addr_q[1:0];
                    end
                    2'b01: begin
                        o_mem_wdata = {2{st_data_q[15:0]}};
                        o_mem_bmask = addr_q[1] ? 4'b1100 : 4'b0011;
                    end
                    default: begin
                        o_mem_wdata = st_data_q;
                        o_mem_bmask = 4'b1111;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed cases plus randomized ops against an arithmetic
// reference of the access rules, with a short ack timeout.
module tb_lsu_mem_stage;

    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_lsu_wren = 1'b0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [31:0] i_alu_data = 32'h0;
    logic [31:0] i_st_data = 32'h0;
    logic        o_busy, o_done, o_err, o_mem_req, o_mem_we;
    logic [31:0] o_ld_data, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = 32'h0;

    int total = 0;
    int bad = 0;
    logic [31:0] last_ld = 32'h0;
    logic        last_err = 1'b0;

    always #5 i_clk = ~i_clk;

    lsu_mem_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_lsu_wren(i_lsu_wren),
        .i_funct3(i_funct3), .i_alu_data(i_alu_data), .i_st_data(i_st_data),
        .o_busy(o_busy), .o_done(o_done), .o_ld_data(o_ld_data), .o_err(o_err),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        i_lsu_wren = 1'($urandom);
        i_funct3   = 3'($urandom);
        i_alu_data = $urandom;
        i_st_data  = $urandom;
    endtask

    // Run one op from IDLE; called at a negedge, returns at the negedge after DONE.
    task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int dly, input logic [31:0] rd);
        int unsigned size, off, sh, v;
        logic exp_err, timeout;
        logic [31:0] exp_wdata, exp_ld, got_ld;
        logic [3:0]  exp_mask;
        int last;
        size = 1 << f3[1:0];
        off  = a % 4;
        exp_err = (f3 == 3) || (f3 > 5) || ((a % size) != 0) || (wr && f3[2]);
        if (size == 1)      exp_wdata = (d & 32'hFF) * 32'h0101_0101;
        else if (size == 2) exp_wdata = (d & 32'hFFFF) * 32'h0001_0001;
        else                exp_wdata = d;
        exp_mask = wr ? 4'(((1 << size) - 1) << off) : 4'b1111;
        sh = rd >> (8 * off);
        if (size == 1) begin
            v = sh % 256;
            exp_ld = (!f3[2] && v >= 128) ? v + 32'hFFFF_FF00 : v;
        end else if (size == 2) begin
            v = sh % 65536;
            exp_ld = (!f3[2] && v >= 32768) ? v + 32'hFFFF_0000 : v;
        end else begin
            exp_ld = rd;
        end

        i_valid = 1'b1; i_lsu_wren = wr; i_funct3 = f3; i_alu_data = a; i_st_data = d;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        scramble();
        if (exp_err) begin
            chk("err_done", o_done, 1);
            chk("err_err", o_err, 1);
            chk("err_noreq", o_mem_req, 0);
            chk("err_busy", o_busy, 1);
            chk("err_ld", o_ld_data, 0);
            last_ld = 0; last_err = 1;
        end else begin
            timeout = (dly >= TO);
            last = timeout ? TO - 1 : dly;
            for (int k = 0; k <= last; k++) begin
                chk("req", o_mem_req, 1);
                chk("done_low", o_done, 0);
                chk("busy", o_busy, 1);
                chk("we", o_mem_we, wr);
                chk("addr", o_mem_addr, a & 32'hFFFF_FFFC);
                chk("bmask", o_mem_bmask, exp_mask);
                if (wr) chk("wdata", o_mem_wdata, exp_wdata);
                i_valid = 1'($urandom);
                scramble();
                if (k == dly) begin
                    i_mem_ack = 1'b1; i_mem_rdata = rd;
                end else begin
                    i_mem_ack = 1'b0; i_mem_rdata = $urandom;
                end
                @(negedge i_clk);
            end
            i_mem_ack = 1'b0; i_valid = 1'b0;
            got_ld = (timeout || wr) ? 32'h0 : exp_ld;
            chk("done", o_done, 1);
            chk("done_err", o_err, timeout);
            chk("ld_data", o_ld_data, got_ld);
            chk("done_noreq", o_mem_req, 0);
            chk("done_busy", o_busy, 1);
            last_ld = got_ld; last_err = timeout;
        end
        @(negedge i_clk);
        chk("idle_busy", o_busy, 0);
        chk("idle_done", o_done, 0);
        chk("hold_ld", o_ld_data, last_ld);
        chk("hold_err", o_err, last_err);
        $display("op wr=%0d f3=%0d addr=%h dly=%0d ld=%h err=%0d", wr, f3, a, dly, o_ld_data, o_err);
    endtask

    // Idle cycles with stray acks that must be ignored.
    task automatic idle_noise(input int n);
        for (int k = 0; k < n; k++) begin
            i_mem_ack = 1'($urandom); i_mem_rdata = $urandom;
            @(negedge i_clk);
            chk("noise_busy", o_busy, 0);
            chk("noise_req", o_mem_req, 0);
            chk("noise_done", o_done, 0);
            chk("noise_ld", o_ld_data, last_ld);
        end
        i_mem_ack = 1'b0;
    endtask

    initial begin
        logic [2:0] legal [5];
        logic wr;
        logic [2:0] f3;
        legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;

        #3;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_req", o_mem_req, 0);
        chk("rst_ld", o_ld_data, 0);
        chk("rst_err", o_err, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_mask", o_mem_bmask, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        run_op(0, 3'b000, 32'h0000_1003, 32'h0, 1, 32'h80FF_1234);
        chk("lb_val", o_ld_data, 32'hFFFF_FF80);
        run_op(0, 3'b101, 32'h0000_2002, 32'h0, 0, 32'hBEEF_0000);
        chk("lhu_val", o_ld_data, 32'h0000_BEEF);
        run_op(0, 3'b001, 32'h0000_2002, 32'h0, 2, 32'hBEEF_0000);
        chk("lh_val", o_ld_data, 32'hFFFF_BEEF);
        run_op(1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 1, 32'h0);
        run_op(1, 3'b000, 32'h0000_3001, 32'h1234_ABCD, 0, 32'h0);
        run_op(1, 3'b010, 32'h0000_3004, 32'hCAFE_F00D, 3, 32'h0);
        run_op(0, 3'b010, 32'h0000_4001, 32'h0, 0, 32'h0);
        run_op(0, 3'b011, 32'h0000_4000, 32'h0, 0, 32'h0);
        run_op(1, 3'b100, 32'h0000_4000, 32'h0, 0, 32'h0);
        run_op(0, 3'b010, 32'h0000_5000, 32'h0, 10, 32'h1111_2222);
        idle_noise(3);

        // Reset during REQ drops the request without a clock edge.
        i_valid = 1'b1; i_lsu_wren = 1'b0; i_funct3 = 3'b010; i_alu_data = 32'h6000;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        chk("pre_rst_req", o_mem_req, 1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_req", o_mem_req, 0);
        chk("arst_busy", o_busy, 0);
        @(posedge i_clk);
        #1;
        chk("arst_done", o_done, 0);
        chk("arst_ld", o_ld_data, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        last_ld = 0; last_err = 0;
        idle_noise(2);

        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom);
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : legal[$urandom_range(0, 4)];
            run_op(wr, f3, $urandom, $urandom, $urandom_range(0, 5), $urandom);
            if ($urandom_range(0, 3) == 0) idle_noise($urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
